// File: rtl/pintador_pkg.sv
// rtl/pintador_pkg.sv - shared types and constants for the quadrant colour painter
package pintador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } sched_state_t;

    localparam logic [2:0] SEC_NONE = 3'b000;
    localparam logic [2:0] SEC_Q1   = 3'b001;
    localparam logic [2:0] SEC_Q2   = 3'b010;
    localparam logic [2:0] SEC_Q3   = 3'b011;
    localparam logic [2:0] SEC_Q4   = 3'b100;

    localparam int H_CENTRO = 320;
    localparam int V_CENTRO = 240;

    // Quadrant index 0..3 maps onto section codes 1..4.
    function automatic logic [2:0] sec_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin pick starting at ptr
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant = 2'd0;
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seccion_scheduler.sv
// rtl/seccion_scheduler.sv - frame-aligned round-robin scheduler for quadrant animation
module seccion_scheduler
    import pintador_pkg::*;
#(
    parameter int DWELL_FRAMES = 30,
    parameter int TICK_DIV     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       clear_req,
    output logic [2:0] seccion_actual,
    output logic       color_tick,
    output logic       reset_color,
    output logic       busy
);

    localparam int FW = $clog2(DWELL_FRAMES + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [FW-1:0] DWELL_LAST = FW'(DWELL_FRAMES);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV);

    sched_state_t  state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    grant, grant_n;
    logic [FW-1:0] frame_cnt, frame_n, frame_inc;
    logic [TW-1:0] tick_cnt, tick_n, tick_inc;
    logic          clear_pend, pend_n;
    logic [2:0]    sec_n;
    logic          tick_n_o, rc_n, busy_n;
    logic          clear_now;
    logic [1:0]    arb_grant;
    logic          arb_valid;

    rr_arbiter4 u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign frame_inc = frame_cnt + FW'(1);
    assign tick_inc  = tick_cnt + TW'(1);
    // A clear arriving on the same cycle as frame_start is honoured immediately.
    assign clear_now = frame_start && (clear_pend || clear_req);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant;
        frame_n  = frame_cnt;
        tick_n   = tick_cnt;
        pend_n   = clear_pend || clear_req;
        sec_n    = seccion_actual;
        tick_n_o = 1'b0;
        rc_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                sec_n = SEC_NONE;
                if (clear_now) begin
                    state_n = ST_CLEAR;
                    rc_n    = 1'b1;
                    pend_n  = 1'b0;
                end else if (frame_start && enable && (req != 4'd0)) begin
                    state_n = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_valid) begin
                    grant_n = arb_grant;
                    sec_n   = sec_code(arb_grant);
                    frame_n = '0;
                    tick_n  = '0;
                    state_n = ST_RUN;
                end else begin
                    sec_n   = SEC_NONE;
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear_now) begin
                    state_n = ST_CLEAR;
                    rc_n    = 1'b1;
                    pend_n  = 1'b0;
                    sec_n   = SEC_NONE;
                end else if (frame_start) begin
                    if (!req[grant] || !enable) begin
                        ptr_n   = grant + 2'd1;
                        sec_n   = SEC_NONE;
                        state_n = ST_IDLE;
                    end else begin
                        frame_n = frame_inc;
                        if (tick_inc == TICK_LAST) begin
                            tick_n_o = 1'b1;
                            tick_n   = '0;
                        end else begin
                            tick_n = tick_inc;
                        end
                        if (frame_inc == DWELL_LAST) begin
                            ptr_n = grant + 2'd1;
                            if (req != 4'd0) begin
                                state_n = ST_ARB;
                            end else begin
                                sec_n   = SEC_NONE;
                                state_n = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_CLEAR: begin
                sec_n   = SEC_NONE;
                state_n = ST_IDLE;
            end
            default: begin
                sec_n   = SEC_NONE;
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            ptr            <= 2'd0;
            grant          <= 2'd0;
            frame_cnt      <= '0;
            tick_cnt       <= '0;
            clear_pend     <= 1'b0;
            seccion_actual <= SEC_NONE;
            color_tick     <= 1'b0;
            reset_color    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            grant          <= grant_n;
            frame_cnt      <= frame_n;
            tick_cnt       <= tick_n;
            clear_pend     <= pend_n;
            seccion_actual <= sec_n;
            color_tick     <= tick_n_o;
            reset_color    <= rc_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: doc/seccion_scheduler.md
# seccion_scheduler

Frame-synchronous controller that decides which screen quadrant's colour generator is animated and when. It drives the section code, the colour-update strobe and the colour-clear pulse consumed by the quadrant colour painter. Four requesters, one per quadrant, share the single animation slot under round-robin arbitration. All changes are aligned to the VGA frame boundary so a quadrant never changes mid-frame.

## Interface
Parameters:
- DWELL_FRAMES, 30: frames a granted quadrant keeps the slot; must be ≥1.
- TICK_DIV, 4: one colour-update strobe every TICK_DIV frames while granted; must be ≥1.

Ports:
- clk  in  1  pixel clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse per frame from VGA timing, at start of vertical blanking.
- enable  in  1  level; scheduler runs only while high.
- req  in  4  level; bit i requests animation of quadrant i+1.
- clear_req  in  1  one-cycle pulse; request to zero all quadrant colours.
- seccion_actual  out  3  section code: 3'b000 none, 3'b001–3'b100 quadrant 1–4.
- color_tick  out  1  one-cycle colour-update strobe; replaces the painter's update clock.
- reset_color  out  1  one-cycle colour-clear pulse.
- busy  out  1  high in ARB, RUN or CLEAR.

## Operation
- States: IDLE, ARB, RUN, CLEAR.
- IDLE: seccion_actual=000. On frame_start with enable=1 and req≠0, go to ARB.
- ARB, one cycle:
  - Round-robin pick: the first set req bit at or after ptr, searching upward mod 4.
  - Latch the grant. Set seccion_actual=grant+1. Clear frame_cnt and tick_cnt. Go to RUN.
- RUN, on each frame_start:
  - frame_cnt++ and tick_cnt++.
  - When tick_cnt reaches TICK_DIV, pulse color_tick and clear tick_cnt.
  - When frame_cnt reaches DWELL_FRAMES: ptr←grant+1 mod 4. Go to ARB if req≠0, else IDLE.
- Early exit from RUN: if the granted req bit is low or enable=0 at a frame_start, give no tick that frame. Set ptr←grant+1 and go to IDLE.
- Clear handling:
  - clear_req is latched into clear_pend in every state.
  - At the next frame_start, clear_pend takes priority over all other transitions: enter CLEAR and pulse reset_color for exactly one cycle.
  - CLEAR then goes to IDLE, with seccion_actual=000 and clear_pend cleared.
- Simultaneous clear_req and frame_start: the clear is taken at that same frame_start.
- Counter widths: frame_cnt is $clog2(DWELL_FRAMES+1) bits; tick_cnt is $clog2(TICK_DIV+1) bits. Neither ever wraps.
- If TICK_DIV > DWELL_FRAMES, RUN produces no ticks.
- frame_start in ARB or CLEAR is ignored and not counted.

## Timing
- All outputs are registered.
- Reset values: seccion_actual=000, color_tick=0, reset_color=0, busy=0, ptr=0, clear_pend=0, state=IDLE.
- reset asserted mid-operation returns everything to these values immediately. A pending clear is discarded.
- frame_start in IDLE at cycle t: state is ARB at t+1; seccion_actual is valid at t+2.
- color_tick and reset_color go high the cycle after the qualifying frame_start, for exactly one cycle.
- seccion_actual changes only in the ARB→RUN cycle or on exit from RUN/CLEAR. It never changes between frame boundaries otherwise.

## Structure
- Shared package pintador_pkg holds:
  - state enum sched_state_t
  - section constants SEC_NONE, SEC_Q1–SEC_Q4
  - H_CENTRO=320 and V_CENTRO=240, used by the painter
- Sub-module rr_arbiter4: combinational 4-way round-robin pick. Inputs req[3:0] and ptr[1:0]; outputs grant[1:0] and valid.

## Test plan
- DWELL=3, TICK_DIV=1, req=0001, enable=1: seccion_actual=001 two cycles after frame 0. Three color_ticks follow, then ARB again, and quadrant 1 is re-granted.
- req=1111, DWELL=2: grant order 001→010→011→100→001. Each quadrant holds for exactly 2 frames.
- req=0101 and ptr=2, then req drops to 0100: quadrant 3 is granted, and from that state quadrant 3 is re-granted while bit 0 stays low.
- During RUN, clear_req arrives mid-frame: one reset_color pulse the cycle after the next frame_start, then IDLE with seccion_actual=000. No color_tick in that frame.
- During RUN, the granted req drops: exit at the next frame_start with no tick, and ptr advances.
- reset pulsed low during RUN with clear_pend=1: all outputs 0 and state IDLE immediately. No reset_color after release.
